// File: rtl/accum_controller.sv
// rtl/accum_controller.sv - UART command sequencer for the 8-bit digit accumulator
//
// Purpose: decodes received ASCII bytes into accumulate / clear / report
// commands. A report waits SETTLE cycles, converts AccQ to decimal, then
// streams the digits plus CR (and LF) to the transmitter.
//
// Ports:
//   CLOCK_50  in   system clock (rising edge)
//   Reset_n   in   asynchronous active-low reset
//   RXData    in   received byte, valid while RXValid=1
//   RXValid   in   one-cycle receive strobe
//   AccQ      in   accumulator output
//   TXReady   in   transmitter idle
//   AccD      out  byte presented to the accumulator
//   AccEnable out  one-cycle accumulate strobe
//   AccClear  out  one-cycle accumulator clear strobe
//   TXData    out  byte to transmit, valid while TXStart=1
//   TXStart   out  one-cycle transmit strobe
//   Busy      out  high whenever the state machine is not idle
//   Error     out  one-cycle strobe: unrecognised byte or overrun
module accum_controller #(
    parameter int SETTLE  = 2,
    parameter bit SEND_LF = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       Reset_n,
    input  logic [7:0] RXData,
    input  logic       RXValid,
    input  logic [7:0] AccQ,
    input  logic       TXReady,
    output logic [7:0] AccD,
    output logic       AccEnable,
    output logic       AccClear,
    output logic [7:0] TXData,
    output logic       TXStart,
    output logic       Busy,
    output logic       Error
);

    // Character slots: 0=hundreds, 1=tens, 2=ones, 3=CR, 4=LF
    localparam logic [2:0] LAST_IDX    = SEND_LF ? 3'd4 : 3'd3;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CONV, S_SEND, S_WAIT_TX
    } state_t;

    state_t     r_state, w_next;
    logic [3:0] r_cnt;
    logic [7:0] r_v;
    logic [1:0] r_h;
    logic [3:0] r_t;
    logic [2:0] r_idx;
    logic       r_last;
    logic       r_wait;

    logic [7:0] r_acc_d, r_tx_data;
    logic       r_acc_en, r_acc_clr, r_tx_start, r_busy, r_error;
    logic [7:0] w_acc_d, w_tx_data, w_char;
    logic       w_acc_en, w_acc_clr, w_tx_start, w_busy, w_error;

    logic w_is_digit, w_is_clear, w_is_report, w_is_skip;

    assign w_is_digit  = (RXData >= 8'h30) && (RXData <= 8'h39);
    assign w_is_clear  = (RXData == 8'h43) || (RXData == 8'h63);
    assign w_is_report = (RXData == 8'h3D) || (RXData == 8'h0D);
    assign w_is_skip   = (RXData == 8'h20) || (RXData == 8'h2B);

    // In SEND, r_v already holds the ones remainder (< 10)
    always_comb begin
        case (r_idx)
            3'd0:    w_char = 8'h30 + {6'b0, r_h};
            3'd1:    w_char = 8'h30 + {4'b0, r_t};
            3'd2:    w_char = 8'h30 + r_v;
            3'd3:    w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (RXValid && w_is_report) w_next = S_SETTLE;
            S_SETTLE:  if (r_cnt == SETTLE_LAST) w_next = S_CONV;
            S_CONV:    if (r_v < 8'd10) w_next = S_SEND;
            S_SEND:    if (TXReady) w_next = S_WAIT_TX;
            // r_wait masks the cycle in which the transmitter has not yet dropped TXReady
            S_WAIT_TX: if (!r_wait && TXReady) w_next = r_last ? S_IDLE : S_SEND;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_acc_d    = r_acc_d;
        w_acc_en   = 1'b0;
        w_acc_clr  = 1'b0;
        w_tx_data  = r_tx_data;
        w_tx_start = 1'b0;
        w_error    = 1'b0;
        w_busy     = (w_next != S_IDLE);
        if (RXValid) begin
            if (r_state != S_IDLE) begin
                w_error = 1'b1;
            end else if (w_is_digit) begin
                w_acc_d  = RXData;
                w_acc_en = 1'b1;
            end else if (w_is_clear) begin
                w_acc_clr = 1'b1;
            end else if (!w_is_report && !w_is_skip) begin
                w_error = 1'b1;
            end
        end
        if (r_state == S_SEND && TXReady) begin
            w_tx_start = 1'b1;
            w_tx_data  = w_char;
        end
    end

    // Output registers and conversion datapath
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc_d    <= 8'd0;
            r_acc_en   <= 1'b0;
            r_acc_clr  <= 1'b0;
            r_tx_data  <= 8'd0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_cnt      <= 4'd0;
            r_v        <= 8'd0;
            r_h        <= 2'd0;
            r_t        <= 4'd0;
            r_idx      <= 3'd0;
            r_last     <= 1'b0;
            r_wait     <= 1'b0;
        end else begin
            r_acc_d    <= w_acc_d;
            r_acc_en   <= w_acc_en;
            r_acc_clr  <= w_acc_clr;
            r_tx_data  <= w_tx_data;
            r_tx_start <= w_tx_start;
            r_busy     <= w_busy;
            r_error    <= w_error;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    r_h   <= 2'd0;
                    r_t   <= 4'd0;
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == SETTLE_LAST) r_v <= AccQ;
                end
                S_CONV: begin
                    if (r_v >= 8'd100) begin
                        r_v <= r_v - 8'd100;
                        r_h <= r_h + 2'd1;
                    end else if (r_v >= 8'd10) begin
                        r_v <= r_v - 8'd10;
                        r_t <= r_t + 4'd1;
                    end else begin
                        // Leading zeros are suppressed; ones digit always sent
                        r_idx <= (r_h != 2'd0) ? 3'd0 : (r_t != 4'd0) ? 3'd1 : 3'd2;
                    end
                end
                S_SEND: begin
                    if (TXReady) begin
                        r_idx  <= r_idx + 3'd1;
                        r_last <= (r_idx == LAST_IDX);
                        r_wait <= 1'b1;
                    end
                end
                S_WAIT_TX: r_wait <= 1'b0;
                default: ;
            endcase
        end
    end

    assign AccD      = r_acc_d;
    assign AccEnable = r_acc_en;
    assign AccClear  = r_acc_clr;
    assign TXData    = r_tx_data;
    assign TXStart   = r_tx_start;
    assign Busy      = r_busy;
    assign Error     = r_error;

endmodule

// File: tb/tb_accum_controller.sv
// tb/tb_accum_controller.sv - directed self-checking bench for accum_controller
module tb_accum_controller;

    logic       CLOCK_50 = 1'b0;
    logic       Reset_n  = 1'b1;
    logic [7:0] RXData   = 8'd0;
    logic       RXValid  = 1'b0;
    logic [7:0] AccQ;
    logic       TXReady  = 1'b1;
    logic [7:0] AccD, TXData;
    logic       AccEnable, AccClear, TXStart, Busy, Error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] en_q[$];
    logic [7:0] tx_q[$];
    int         n_clr  = 0;
    int         n_err  = 0;
    int         n_viol = 0;
    logic       prev_start = 1'b0;
    int         tx_cnt = 0;
    logic       tx_hold = 1'b0;
    logic [7:0] acc_sum;

    accum_controller #(.SETTLE(2), .SEND_LF(1'b1)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset_n  (Reset_n),
        .RXData   (RXData),
        .RXValid  (RXValid),
        .AccQ     (AccQ),
        .TXReady  (TXReady),
        .AccD     (AccD),
        .AccEnable(AccEnable),
        .AccClear (AccClear),
        .TXData   (TXData),
        .TXStart  (TXStart),
        .Busy     (Busy),
        .Error    (Error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Behavioural accumulator: sum register followed by output register
    always @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_sum <= 8'd0;
            AccQ    <= 8'd0;
        end else begin
            if (AccClear)       acc_sum <= 8'd0;
            else if (AccEnable) acc_sum <= acc_sum + {4'd0, AccD[3:0]};
            AccQ <= acc_sum;
        end
    end

    // Monitor and transmitter model, evaluated on the falling edge
    always @(negedge CLOCK_50) begin
        if (Reset_n) begin
            if (AccEnable) en_q.push_back(AccD);
            if (AccClear)  n_clr++;
            if (Error)     n_err++;
            if (TXStart) begin
                tx_q.push_back(TXData);
                if (!TXReady || prev_start) n_viol++;
            end
        end
        prev_start = TXStart;
        if (TXStart) begin
            TXReady = 1'b0;
            tx_cnt  = 5;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end else begin
            TXReady = !tx_hold;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        RXData  = b;
        RXValid = 1'b1;
        @(negedge CLOCK_50);
        RXValid = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge CLOCK_50);
        #1;
        en_q.delete();
        tx_q.delete();
        n_clr = 0;
        n_err = 0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (Busy && k < 600) begin
            @(negedge CLOCK_50);
            k++;
        end
        check(tag, {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic check_tx(input string tag, input int n, input logic [39:0] exp);
        check({tag, " count"}, tx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] o;
            o = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
            check(tag, {24'd0, o}, {24'd0, exp[8*(n-1-i) +: 8]});
        end
    endtask

    initial begin
        // Reset with random inputs
        #3 Reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            RXData  = 8'($urandom);
            RXValid = 1'($urandom_range(0, 1));
            #1;
            check("reset outputs", {AccD, AccEnable, AccClear, TXData, TXStart, Busy, Error}, 32'd0);
        end
        @(negedge CLOCK_50);
        RXValid = 1'b0;
        Reset_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge CLOCK_50);
        check("idle busy", {31'd0, Busy}, 32'd0);
        check("idle strobes", n_clr + n_err + en_q.size() + tx_q.size(), 0);

        // '1','2','3','=' -> "6\r\n"
        send_byte(8'h31);
        check("digit timing", {AccEnable, AccD}, {1'b1, 8'h31});
        @(negedge CLOCK_50);
        check("digit one cycle", {31'd0, AccEnable}, 32'd0);
        send_byte(8'h32);
        send_byte(8'h33);
        send_byte(8'h3D);
        check("busy after report", {31'd0, Busy}, 32'd1);
        wait_idle("report 6 done");
        check("enable count", en_q.size(), 3);
        check("accd 0", en_q.size() > 0 ? {24'd0, en_q[0]} : 32'hFFFF, 32'h31);
        check("accd 1", en_q.size() > 1 ? {24'd0, en_q[1]} : 32'hFFFF, 32'h32);
        check("accd 2", en_q.size() > 2 ? {24'd0, en_q[2]} : 32'hFFFF, 32'h33);
        check_tx("tx 6", 3, 40'h36_0D_0A);

        // Clear, 28x'9' + '3' = 255, then wrap to 8 (digit back-to-back with '=')
        clear_mon();
        send_byte(8'h43);
        for (int i = 0; i < 28; i++) send_byte(8'h39);
        send_byte(8'h33);
        send_byte(8'h3D);
        wait_idle("report 255 done");
        check("clear count", n_clr, 1);
        check_tx("tx 255", 5, 40'h32_35_35_0D_0A);
        clear_mon();
        send_byte(8'h39);
        send_byte(8'h3D);
        wait_idle("report 8 done");
        check_tx("tx wrap 8", 3, 40'h38_0D_0A);

        // 105 with embedded zero, then 'c' -> 0
        clear_mon();
        send_byte(8'h43);
        for (int i = 0; i < 11; i++) send_byte(8'h39);
        send_byte(8'h36);
        send_byte(8'h0D);
        wait_idle("report 105 done");
        check_tx("tx 105", 5, 40'h31_30_35_0D_0A);
        clear_mon();
        send_byte(8'h63);
        send_byte(8'h3D);
        wait_idle("report 0 done");
        check("lower c clear", n_clr, 1);
        check_tx("tx 0", 3, 40'h30_0D_0A);

        // Unrecognised byte and silently ignored bytes
        clear_mon();
        send_byte(8'h78);
        send_byte(8'h20);
        send_byte(8'h2B);
        repeat (3) @(negedge CLOCK_50);
        check("bad byte error", n_err, 1);
        check("bad byte no enable", en_q.size(), 0);
        check("bad byte idle", {31'd0, Busy}, 32'd0);

        // Overrun while parked in SEND
        send_byte(8'h37);
        clear_mon();
        tx_hold = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        send_byte(8'h3D);
        repeat (25) @(negedge CLOCK_50);
        send_byte(8'h35);
        @(negedge CLOCK_50);
        check("overrun error", n_err, 1);
        check("overrun no enable", en_q.size(), 0);
        check("overrun held", tx_q.size(), 0);
        tx_hold = 1'b0;
        wait_idle("overrun report done");
        check_tx("tx overrun", 3, 40'h37_0D_0A);

        // Reset during WAIT_TX of the second digit
        clear_mon();
        send_byte(8'h43);
        for (int i = 0; i < 4; i++) send_byte(8'h39);
        send_byte(8'h3D);
        begin
            int k;
            k = 0;
            while (tx_q.size() < 2 && k < 300) begin
                @(negedge CLOCK_50);
                #1;
                k++;
            end
            check("second digit reached", tx_q.size(), 2);
        end
        Reset_n = 1'b0;
        #1;
        check("async reset outputs", {29'd0, TXStart, Busy, Error}, 32'd0);
        repeat (3) @(negedge CLOCK_50);
        Reset_n = 1'b1;
        clear_mon();
        repeat (8) @(negedge CLOCK_50);
        check("post reset quiet", tx_q.size(), 0);
        send_byte(8'h3D);
        wait_idle("post reset report done");
        check_tx("tx post reset", 3, 40'h30_0D_0A);

        check("tx strobe rules", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
